// File: rtl/step_controller_if.sv
// Button/halt inputs and step/display outputs of the execution sequencer.
// The controller takes the slave side; the board or bench drives the master side.
interface step_controller_if;
  logic        btn_step;
  logic        btn_mode;
  logic        halt_req;
  logic        step_en;
  logic        sample_en;
  logic        mode_run;
  logic        halted;
  logic [15:0] step_count;

  modport master (
    output btn_step, btn_mode, halt_req,
    input  step_en, sample_en, mode_run, halted, step_count
  );

  modport slave (
    input  btn_step, btn_mode, halt_req,
    output step_en, sample_en, mode_run, halted, step_count
  );
endinterface

// File: rtl/step_controller.sv
// Execution sequencer: debounced pushbuttons drive a one-cycle step strobe in
// single-step or free-running mode, with a halt state and a wrapping step counter.
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV         = 25_000_000
) (
  input  logic             clk,
  input  logic             n_rst,
  step_controller_if.slave bus
);
  // state   | meaning
  // ST_STEP | one step per debounced step press
  // ST_RUN  | one step every RUN_DIV cycles
  // ST_HALT | queue reported empty; only a mode press leaves
  typedef enum logic [1:0] {ST_STEP, ST_RUN, ST_HALT} state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(RUN_DIV - 1);

  // Bit 0 carries the step button, bit 1 the mode button.
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         lvl_q, lvl_d, lvl_prev_q;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]         press_q;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          step_en_q, step_en_d;
  logic          sample_en_q;
  logic [15:0]   step_count_q;
  logic          p_step, p_mode, tick_last;

  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign p_step    = press_q[0];
  assign p_mode    = press_q[1];
  assign tick_last = (tick_q == TICK_LAST);

  // A mode press always takes priority over a step or a terminal count.
  always_comb begin
    state_d   = state_q;
    tick_d    = '0;
    step_en_d = 1'b0;
    case (state_q)
      ST_STEP: begin
        if (p_mode) begin
          state_d = ST_RUN;
        end else if (p_step) begin
          if (bus.halt_req) state_d   = ST_HALT;
          else              step_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        tick_d = tick_last ? '0 : tick_q + 1'b1;
        if (p_mode) begin
          state_d = ST_STEP;
          tick_d  = '0;
        end else if (tick_last) begin
          if (bus.halt_req) state_d   = ST_HALT;
          else              step_en_d = 1'b1;
        end
      end
      ST_HALT: begin
        if (p_mode) state_d = ST_STEP;
      end
      default: state_d = ST_STEP;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      lvl_q        <= '0;
      lvl_prev_q   <= '0;
      db_cnt_q     <= '0;
      press_q      <= '0;
      state_q      <= ST_STEP;
      tick_q       <= '0;
      step_en_q    <= 1'b0;
      sample_en_q  <= 1'b0;
      step_count_q <= '0;
    end else begin
      sync1_q      <= {bus.btn_mode, bus.btn_step};
      sync2_q      <= sync1_q;
      lvl_q        <= lvl_d;
      lvl_prev_q   <= lvl_q;
      db_cnt_q     <= db_cnt_d;
      press_q      <= lvl_q & ~lvl_prev_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      step_en_q    <= step_en_d;
      sample_en_q  <= step_en_q;
      if (step_en_q) step_count_q <= step_count_q + 16'd1;
    end
  end

  assign bus.step_en    = step_en_q;
  assign bus.sample_en  = sample_en_q;
  assign bus.mode_run   = (state_q == ST_RUN);
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.step_count = step_count_q;
endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: expected step_en cycles are queued as buttons are
// driven and popped as the strobe appears; state and counter are spot-checked.
module tb_step_controller;
  localparam int DB = 4;
  localparam int RD = 8;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  step_controller_if bus ();

  step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int          cyc = 0;
  int          n_err = 0;
  int          n_chk = 0;
  int          exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic        exp_prev = 1'b0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the next negative edge and compare the strobes against the queue.
  task automatic next_cycle();
    logic e;
    @(negedge clk);
    if (mon_en) begin
      e = (exp_q.size() > 0) && (exp_q[0] == cyc);
      check_val("step_en", 32'(bus.step_en), 32'(e));
      check_val("sample_en", 32'(bus.sample_en), 32'(exp_prev));
      if (e) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
      exp_prev = e;
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic press(input bit step_b, input bit mode_b, input int hold);
    if (step_b) bus.btn_step = 1'b1;
    if (mode_b) bus.btn_mode = 1'b1;
    repeat (hold) next_cycle();
    bus.btn_step = 1'b0;
    bus.btn_mode = 1'b0;
    repeat (12) next_cycle();
  endtask

  initial begin
    int n0, r, m;
    bus.btn_step = 1'b0;
    bus.btn_mode = 1'b0;
    bus.halt_req = 1'b0;

    // Reset defaults
    repeat (3) next_cycle();
    check_val("rst_step_en", 32'(bus.step_en), 32'd0);
    check_val("rst_count", 32'(bus.step_count), 32'd0);
    n_rst  = 1'b1;
    mon_en = 1'b1;
    repeat (50) next_cycle();
    check_val("idle_mode_run", 32'(bus.mode_run), 32'd0);
    check_val("idle_halted", 32'(bus.halted), 32'd0);
    check_val("idle_count", 32'(bus.step_count), 32'd0);

    // Single steps and glitch rejection
    exp_q.push_back(cyc + 8);
    press(1'b1, 1'b0, 10);
    check_val("count_one", 32'(bus.step_count), 32'd1);
    press(1'b1, 1'b0, 3);
    exp_q.push_back(cyc + 8);
    press(1'b1, 1'b0, 6);
    check_val("count_two", 32'(bus.step_count), 32'(exp_cnt));

    // RUN cadence; the exit press lands on a terminal count
    n0 = cyc;
    r  = n0 + 8;
    m  = r + 80;
    for (int t = r + RD; t < m + 8; t += RD) exp_q.push_back(t);
    press(1'b0, 1'b1, 10);
    check_val("run_mode_run", 32'(bus.mode_run), 32'd1);
    wait_to(m);
    press(1'b0, 1'b1, 10);
    check_val("run_exit_mode", 32'(bus.mode_run), 32'd0);
    repeat (20) next_cycle();
    check_val("run_count", 32'(bus.step_count), 32'(exp_cnt));
    check_val("run_pending", 32'(exp_q.size()), 32'd0);

    // Halt entered at a terminal count, left only by a mode press
    n0 = cyc;
    r  = n0 + 8;
    exp_q.push_back(r + 8);
    exp_q.push_back(r + 16);
    press(1'b0, 1'b1, 10);
    wait_to(r + 18);
    bus.halt_req = 1'b1;
    wait_to(r + 23);
    check_val("pre_halt_halted", 32'(bus.halted), 32'd0);
    check_val("pre_halt_run", 32'(bus.mode_run), 32'd1);
    next_cycle();
    check_val("halt_halted", 32'(bus.halted), 32'd1);
    check_val("halt_run", 32'(bus.mode_run), 32'd0);
    bus.halt_req = 1'b0;
    repeat (20) next_cycle();
    check_val("halt_sticky", 32'(bus.halted), 32'd1);
    press(1'b1, 1'b0, 10);
    check_val("halt_step_ign", 32'(bus.halted), 32'd1);
    check_val("halt_count", 32'(bus.step_count), 32'(exp_cnt));
    bus.btn_mode = 1'b1;
    repeat (7) next_cycle();
    check_val("unhalt_before", 32'(bus.halted), 32'd1);
    next_cycle();
    check_val("unhalt_after", 32'(bus.halted), 32'd0);
    check_val("unhalt_run", 32'(bus.mode_run), 32'd0);
    repeat (2) next_cycle();
    bus.btn_mode = 1'b0;
    repeat (12) next_cycle();

    // Simultaneous presses, then counter wrap and async reset in RUN
    n0 = cyc;
    for (int k = 2; k <= 6; k++) exp_q.push_back(n0 + k * RD);
    press(1'b1, 1'b1, 10);
    check_val("sim_mode_run", 32'(bus.mode_run), 32'd1);
    wait_to(n0 + 26);
    force dut.step_count_q = 16'hFFFD;
    #1;
    release dut.step_count_q;
    exp_cnt = 16'hFFFD;
    wait_to(n0 + 50);
    check_val("wrap_model", 32'(bus.step_count), 32'(exp_cnt));
    check_val("wrap_zero", 32'(bus.step_count), 32'h0000);
    wait_to(n0 + 52);
    check_val("pre_rst_run", 32'(bus.mode_run), 32'd1);
    n_rst = 1'b0;
    #1;
    check_val("arst_step_en", 32'(bus.step_en), 32'd0);
    check_val("arst_sample_en", 32'(bus.sample_en), 32'd0);
    check_val("arst_mode_run", 32'(bus.mode_run), 32'd0);
    check_val("arst_halted", 32'(bus.halted), 32'd0);
    exp_cnt = '0;
    exp_prev = 1'b0;
    repeat (3) next_cycle();
    n_rst = 1'b1;
    repeat (20) next_cycle();
    check_val("post_rst_run", 32'(bus.mode_run), 32'd0);
    check_val("post_rst_count", 32'(bus.step_count), 32'd0);
    exp_q.push_back(cyc + 8);
    press(1'b1, 1'b0, 10);
    check_val("post_rst_step", 32'(bus.step_count), 32'd1);
    check_val("final_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/step_controller.md
# step_controller

Execution sequencer for the dual-issue core. It turns the board pushbuttons into a single-cycle advance strobe, `step_en`, in the 100 MHz `clk` domain. This replaces the divided 1 Hz clock that drives the instruction queue and scheduler. The block supports a free-running mode (one step every `RUN_DIV` cycles), a single-step mode (one step per debounced press) and a halt state entered when the scheduler reports an empty queue. It also produces the display sample strobe and a step counter for the 7-segment debug readout.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz); must be ≥1.
- `RUN_DIV`, default 25_000_000: period of `step_en` in RUN mode, in `clk` cycles; must be ≥2.
- `clk` in 1: system clock, 100 MHz.
- `n_rst` in 1: reset, asynchronous, active-low.
- `btn_step` in 1: raw step pushbutton, asynchronous, active-high.
- `btn_mode` in 1: raw mode pushbutton, asynchronous, active-high; toggles STEP and RUN.
- `halt_req` in 1: scheduler `nothing_filled`, synchronous to `clk`.
- `step_en` out 1: one-cycle advance strobe to the queue, scheduler and register-file write enable.
- `sample_en` out 1: `step_en` delayed one cycle; latches the ALU result into the display register.
- `mode_run` out 1: 1 while in RUN.
- `halted` out 1: 1 while in HALT.
- `step_count` out 16: number of `step_en` pulses issued; wraps modulo 2^16.

## Operation
- **Input conditioning.** Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer counter clears whenever the synced value equals the debounced level.
  - The counter increments while the two differ.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, the debounced level flips and the counter clears.
- **Press pulse.** A rising edge of a debounced level produces a one-cycle internal press pulse (`p_step`, `p_mode`). Releases produce nothing.
- **States:** STEP, RUN, HALT. Reset state is STEP.
- **STEP:**
  - `p_mode` → RUN; the tick counter clears.
  - `p_step` with `halt_req`=0 → issue `step_en`, stay in STEP.
  - `p_step` with `halt_req`=1 → no `step_en`; go to HALT.
- **RUN:**
  - The tick counter counts 0..RUN_DIV-1 and wraps to 0.
  - On the terminal count with `halt_req`=0 → issue `step_en`.
  - On the terminal count with `halt_req`=1 → no `step_en`; go to HALT.
  - `p_mode` → STEP; the tick counter clears.
  - `p_step` is ignored.
- **HALT:**
  - No `step_en`.
  - `p_mode` → STEP.
  - `p_step` is ignored.
  - `halt_req` deasserting does not leave HALT.
- **Simultaneous events:**
  - `p_mode` and `p_step` in the same cycle: `p_mode` wins; the step is dropped.
  - `p_mode` coincident with the RUN terminal count: `p_mode` wins; no `step_en`.
- **Counters and derived outputs:**
  - `step_count` increments in the cycle `step_en` is high; 0xFFFF wraps to 0x0000.
  - `halted` and `mode_run` decode the registered state.
  - `sample_en` is a registered copy of `step_en`.

## Timing
- **Reset.** Asserting `n_rst` low immediately forces:
  - outputs: `step_en`=0, `sample_en`=0, `mode_run`=0, `halted`=0, `step_count`=0;
  - internal: state=STEP, all counters 0, synchronizers 0, debounced levels 0.
- **Reset mid-operation.** Reset during RUN or HALT, or mid-debounce, behaves identically. A button held through reset release registers as a press once it is debounced.
- **Button latency.** From the first clock edge where the raw button is seen high, with the button held stable:
  - 2 cycles of synchronizer;
  - DEBOUNCE_CYCLES cycles to flip the debounced level;
  - +1 cycle to the press pulse;
  - +1 cycle to `step_en`.
- **Glitches.** A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- **RUN period.** The first `step_en` comes exactly RUN_DIV cycles after the cycle in which the state becomes RUN. Later pulses are exactly RUN_DIV cycles apart.
- **Pulse width.** `step_en` is never high for two consecutive cycles. `sample_en` follows `step_en` by exactly 1 cycle.
- **State outputs.** `mode_run` and `halted` change the cycle after the triggering press or terminal count.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, RUN_DIV=8.
- **Reset defaults.** Hold `n_rst`=0 for 3 cycles, then release with no buttons pressed → all outputs 0 for 50 cycles; `step_count`=0.
- **Single step and bounce rejection.**
  - Pulse `btn_step` high for 10 cycles → exactly one `step_en`, 8 cycles after the rise; `sample_en` the next cycle; `step_count`=1.
  - 3-cycle high glitch → no `step_en`.
- **RUN cadence and return to STEP.**
  - Press `btn_mode` → `mode_run`=1.
  - Over 80 further cycles → `step_en` every 8 cycles.
  - Press `btn_mode` again → `mode_run`=0, pulses stop.
  - `step_count` equals the number of pulses observed.
- **Halt.**
  - In RUN, raise `halt_req` → at the next terminal count no `step_en`; `halted`=1 from the next cycle.
  - Drop `halt_req` → stays halted.
  - `btn_step` press → ignored.
  - `btn_mode` press → STEP, `halted`=0.
- **Simultaneous presses.** Raise `btn_mode` and `btn_step` on the same cycle in STEP → RUN entered; no `step_en` on the press cycle.
- **Counter wrap and async reset.**
  - Force 65 536 steps in RUN → `step_count` returns to 0x0000.
  - Assert `n_rst` low mid-period → outputs clear immediately, and the state is STEP after release.
